// File: rtl/systolic_stream_ctrl_pkg.sv
// Shared types and latency helper for the systolic stream controller.
package systolic_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Edges from row acceptance to the aligned result appearing at out_data.
    function automatic int out_latency(input int array_lat, input int k);
        return array_lat + k;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth per-lane delay line; DEPTH=0 is a plain wire.
module skew_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_stream_ctrl.sv
// Job controller for a systolic array: latches weights, skews X rows into the
// array, deskews Y rows back out and frames the job with out_last/done.
module systolic_stream_ctrl
    import systolic_stream_ctrl_pkg::*;
#(
    parameter int M          = 5,
    parameter int N          = 3,
    parameter int K          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_LAT  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH*N*K-1:0] w_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH*N-1:0]   in_data,
    output logic [DATA_WIDTH*N-1:0]   arr_x,
    output logic [DATA_WIDTH*N*K-1:0] arr_w,
    input  logic [DATA_WIDTH*K-1:0]   arr_y,
    output logic                      out_valid,
    output logic [DATA_WIDTH*K-1:0]   out_data,
    output logic                      out_last,
    output logic                      done
);

    localparam int LAT = out_latency(ARRAY_LAT, K);
    localparam int CW  = (M > 1) ? $clog2(M) : 1;

    state_t                      state_q;
    logic [CW-1:0]               row_cnt_q;
    logic [CW-1:0]               out_cnt_q;
    logic [DATA_WIDTH*N*K-1:0]   w_q;
    logic [DATA_WIDTH*N-1:0]     row_q, row_d;
    logic [LAT-1:0]              vld_q, vld_d;
    logic [DATA_WIDTH*K-1:0]     y_aligned;
    logic                        accept;
    logic                        row_last;

    assign accept    = (state_q == FEED) && in_valid;
    assign row_last  = (row_cnt_q == CW'(M - 1));
    assign in_ready  = (state_q == FEED);
    assign done      = (state_q == DONE);
    assign arr_w     = w_q;
    assign out_valid = vld_q[LAT-1];
    assign out_last  = out_valid && (out_cnt_q == CW'(M - 1));
    assign out_data  = out_valid ? y_aligned : '0;

    // Non-accept cycles feed a zero row so bubbles travel through the skew.
    assign row_d = accept ? in_data : '0;
    assign vld_d = {vld_q[LAT-2:0], accept};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            out_cnt_q <= '0;
            w_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= FEED;
                        w_q       <= w_in;
                        row_cnt_q <= '0;
                    end
                end
                FEED: begin
                    if (in_valid) begin
                        if (row_last) begin
                            state_q   <= DRAIN;
                            row_cnt_q <= '0;
                        end else begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_last) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (out_valid) begin
                out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            vld_q <= '0;
        end else begin
            row_q <= row_d;
            vld_q <= vld_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            skew_line #(
                .DEPTH      (gi),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_skew (
                .clk (clk),
                .rst (rst),
                .d_i (row_q[gi*DATA_WIDTH +: DATA_WIDTH]),
                .q_o (arr_x[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end

        // Lane j leaves the array j cycles after lane 0; pad so all lanes meet lane K-1.
        for (gi = 0; gi < K; gi++) begin : g_deskew
            skew_line #(
                .DEPTH      (K - 1 - gi),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_deskew (
                .clk (clk),
                .rst (rst),
                .d_i (arr_y[gi*DATA_WIDTH +: DATA_WIDTH]),
                .q_o (y_aligned[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// Randomized scoreboard bench for systolic_stream_ctrl with a behavioural array model.
module tb_systolic_stream_ctrl;

    localparam int DW = 8;
    localparam int N  = 3;
    localparam int K  = 4;
    localparam int AL = 3;
    localparam int M  = 5;
    localparam int L  = AL + K;

    logic              clk;
    logic              rst;
    logic              start;
    logic [DW*N*K-1:0] w_in;
    logic              in_valid;
    logic              in_ready;
    logic [DW*N-1:0]   in_data;
    logic [DW*N-1:0]   arr_x;
    logic [DW*N*K-1:0] arr_w;
    logic [DW*K-1:0]   arr_y;
    logic              out_valid;
    logic [DW*K-1:0]   out_data;
    logic              out_last;
    logic              done;

    systolic_stream_ctrl #(
        .M (M), .N (N), .K (K), .DATA_WIDTH (DW), .ARRAY_LAT (AL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .w_in      (w_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .arr_x     (arr_x),
        .arr_w     (arr_w),
        .arr_y     (arr_y),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    typedef struct {
        logic [DW*K-1:0] data;
        logic            last;
        int              cyc;
    } exp_t;

    exp_t              sb[$];
    logic [DW*N-1:0]   acc_row [int];
    logic [DW*N-1:0]   xhist   [int];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    bit                armed    = 0;
    bit                active   = 0;
    bit                feeding  = 0;
    int                rows     = 0;
    int                done_cyc = -1;
    logic [DW*N*K-1:0] wlat     = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Behavioural array: lane j of a row's result is X[j mod N] xor weight byte j,
    // delivered ARRAY_LAT+j cycles after that row's lane 0 entered the array.
    initial begin
        arr_y = '0;
        forever begin
            logic [DW*K-1:0] y;
            logic [DW*N-1:0] xr;
            @(posedge clk);
            #1;
            y = '0;
            for (int j = 0; j < K; j++) begin
                int key;
                key = cyc - AL - j + (j % N);
                xr  = xhist.exists(key) ? xhist[key] : '0;
                y[j*DW +: DW] = xr[(j % N)*DW +: DW] ^ arr_w[j*DW +: DW];
            end
            arr_y = y;
        end
    end

    // Monitor and reference model: checks this cycle's outputs, then advances
    // the job model using the inputs the next rising edge will sample.
    always @(negedge clk) begin
        logic [DW*N-1:0] ex;
        logic [DW*N-1:0] tmp;
        logic [DW*K-1:0] ed;
        exp_t            e;
        bit              exp_v;
        if (armed) begin
            chk("in_ready", 96'(in_ready), 96'(feeding));
            chk("done", 96'(done), 96'(done_cyc == cyc));
            chk("arr_w", 96'(arr_w), 96'(wlat));
            ex = '0;
            for (int i = 0; i < N; i++) begin
                if (acc_row.exists(cyc - i)) begin
                    tmp = acc_row[cyc - i];
                    ex[i*DW +: DW] = tmp[i*DW +: DW];
                end
            end
            chk("arr_x", 96'(arr_x), 96'(ex));
            while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("out_valid", 96'(out_valid), 96'(exp_v));
            if (out_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", 96'(out_data), 96'(e.data));
                chk("out_last", 96'(out_last), 96'(e.last));
                if (e.last) done_cyc = cyc + 1;
            end else begin
                chk("out_idle_zero", 96'({out_data, out_last}), 96'(0));
            end
        end
        xhist[cyc] = arr_x;
        if (rst === 1'b1) begin
            sb.delete();
            acc_row.delete();
            active   = 0;
            feeding  = 0;
            rows     = 0;
            wlat     = '0;
            done_cyc = -1;
            armed    = 1;
        end else begin
            if (feeding && in_valid === 1'b1) begin
                acc_row[cyc + 1] = in_data;
                rows++;
                for (int j = 0; j < K; j++) begin
                    ed[j*DW +: DW] = in_data[(j % N)*DW +: DW] ^ wlat[j*DW +: DW];
                end
                e.data = ed;
                e.last = (rows == M);
                e.cyc  = cyc + L;
                sb.push_back(e);
                if (rows == M) feeding = 0;
            end else if (!active && start === 1'b1) begin
                active  = 1;
                feeding = 1;
                rows    = 0;
                wlat    = w_in;
            end
            if (active && done_cyc == cyc) active = 0;
        end
    end

    task automatic drive(input logic st, input logic iv, input logic [DW*N-1:0] d,
                         input logic [DW*N*K-1:0] w, input logic r);
        start    = st;
        in_valid = iv;
        in_data  = d;
        w_in     = w;
        rst      = r;
        @(posedge clk);
        #2;
    endtask

    localparam logic [DW*N*K-1:0] W1 = 96'h0123456789abcdef02468ace;
    localparam logic [DW*N*K-1:0] W2 = 96'hfedcba987654321013579bdf;
    localparam logic [DW*N*K-1:0] W3 = 96'h5a5aa5a5c3c33c3c0ff0f00f;

    logic [DW*N-1:0] rows_tab [5];

    initial begin
        rows_tab[0] = 24'h010203;
        rows_tab[1] = 24'h030201;
        rows_tab[2] = 24'h010302;
        rows_tab[3] = 24'h040404;
        rows_tab[4] = 24'h050505;

        repeat (3) drive(0, 0, '0, '0, 1);
        repeat (2) drive(0, 0, '0, '0, 0);

        // Back-to-back job
        drive(1, 0, '0, W1, 0);
        for (int k = 0; k < 5; k++) drive(0, 1, rows_tab[k], W1, 0);
        repeat (15) drive(0, 0, '0, W1, 0);

        // Two-cycle gap after row 2
        drive(1, 0, '0, W2, 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) repeat (2) drive(0, 0, 24'hdeadbe, W2, 0);
            drive(0, 1, rows_tab[k], W2, 0);
        end
        repeat (15) drive(0, 0, '0, W2, 0);

        // Reset after three accepts, then a clean job
        drive(1, 0, '0, W3, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, rows_tab[k], W3, 0);
        drive(0, 0, '0, W3, 1);
        repeat (12) drive(0, 0, '0, W3, 0);

        // Start pulses with new weights during FEED are ignored
        drive(1, 0, '0, W1, 0);
        for (int k = 0; k < 5; k++) drive(1, 1, 24'h112233 + 24'(k), W2, 0);
        repeat (15) drive(0, 0, '0, W1, 0);

        // Start held through DRAIN/DONE is honoured only once IDLE is reached
        drive(1, 0, '0, W2, 0);
        for (int k = 0; k < 5; k++) drive(0, 1, rows_tab[4-k], W2, 0);
        repeat (14) drive(1, 0, '0, W3, 0);
        for (int k = 0; k < 5; k++) drive(0, 1, rows_tab[k], W1, 0);
        repeat (15) drive(0, 0, '0, W1, 0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2500; c++) begin
            drive(logic'($urandom_range(15) == 0),
                  logic'($urandom_range(9) < 6),
                  24'($urandom),
                  {$urandom, $urandom, $urandom},
                  logic'($urandom_range(399) == 0));
        end

        repeat (25) drive(0, 0, '0, '0, 0);
        chk("scoreboard_drained", 96'(sb.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
